// File: rtl/pcie_tlp_pkg.sv
// pcie_tlp_pkg: TLP header codes, FSM encoding and limits shared by the TX TLP builder.
package pcie_tlp_pkg;
    localparam logic [1:0] FMT_3DW_DATA  = 2'b10;
    localparam logic [4:0] TYPE_MWR      = 5'b00000;
    localparam logic [4:0] TYPE_CPL      = 5'b01010;
    localparam logic [5:0] TX_BUF_AV_MIN = 6'd2;
    localparam int         MAX_LEN_DW    = 1024;

    typedef enum logic [2:0] {IDLE, HDR0, HDR1, HDR2, DATA} state_t;

    // 3DW header with payload: tc/td/ep/attr all zero
    function automatic logic [31:0] tlp_dw0(input logic cpl, input logic [9:0] len);
        return {1'b0, FMT_3DW_DATA, cpl ? TYPE_CPL : TYPE_MWR, 1'b0, 3'b000, 4'b0000,
                1'b0, 1'b0, 2'b00, 2'b00, len};
    endfunction
endpackage

// File: rtl/pcie_tx_tlp_builder.sv
// pcie_tx_tlp_builder: serialises MWr32/CplD TLPs onto the PCIe core's 32-bit AXI-stream TX port.
// Define PCIE_TX_BUF_THROTTLE_EN to hold off new requests while tx_buf_av is below TX_BUF_AV_MIN.
module pcie_tx_tlp_builder
    import pcie_tlp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_type,
    input  logic [9:0]  i_len,
    input  logic [31:0] i_addr,
    input  logic [7:0]  i_tag,
    input  logic [15:0] i_req_id,
    input  logic [15:0] i_cpl_id,
    input  logic [11:0] i_byte_count,
    input  logic [31:0] i_data,
    input  logic        i_data_valid,
    output logic        o_data_ready,
    output logic [31:0] s_axis_tx_tdata,
    output logic [3:0]  s_axis_tx_tkeep,
    output logic [3:0]  s_axis_tx_tuser,
    output logic        s_axis_tx_tlast,
    output logic        s_axis_tx_tvalid,
    input  logic        s_axis_tx_tready,
    input  logic [5:0]  tx_buf_av,
    output logic        o_busy,
    output logic [31:0] o_tlp_count
);
    state_t      state, state_nxt;
    logic        r_cpl;
    logic [9:0]  r_len;
    logic [31:0] r_addr;
    logic [7:0]  r_tag;
    logic [15:0] r_req_id, r_cpl_id;
    logic [11:0] r_byte_count;
    logic [10:0] remaining;
    logic        free, accept, load_data, done, can_start;
    logic        tvalid_nxt, tlast_nxt;
    logic [31:0] tdata_nxt, dw1, dw2;

    assign free = !s_axis_tx_tvalid || s_axis_tx_tready;
    assign done = state == DATA && s_axis_tx_tvalid && s_axis_tx_tready && s_axis_tx_tlast;
`ifdef PCIE_TX_BUF_THROTTLE_EN
    assign can_start = tx_buf_av >= TX_BUF_AV_MIN;
`else
    logic unused_tx_buf_av;
    assign unused_tx_buf_av = ^tx_buf_av;
    assign can_start = 1'b1;
`endif
    assign o_req_ready     = state == IDLE && !rst && can_start;
    assign accept          = i_req_valid && o_req_ready;
    assign o_data_ready    = state == DATA && free && remaining != 11'd0;
    assign load_data       = o_data_ready && i_data_valid;
    assign o_busy          = state != IDLE;
    assign s_axis_tx_tkeep = 4'hF;
    assign s_axis_tx_tuser = 4'h0;
    assign dw1 = r_cpl ? {r_cpl_id, 3'b000, 1'b0, r_byte_count}
                       : {r_req_id, r_tag, r_len == 10'd1 ? 4'h0 : 4'hF, 4'hF};
    assign dw2 = r_cpl ? {r_req_id, r_tag, 1'b0, r_addr[6:0]} : {r_addr[31:2], 2'b00};

    // The state names the beat held in the output register; DW0 is loaded on the accept edge.
    always_comb begin
        state_nxt  = state;
        tvalid_nxt = s_axis_tx_tvalid;
        tlast_nxt  = s_axis_tx_tlast;
        tdata_nxt  = s_axis_tx_tdata;
        case (state)
            IDLE: if (accept) begin
                state_nxt  = HDR0;
                tvalid_nxt = 1'b1;
                tlast_nxt  = 1'b0;
                tdata_nxt  = tlp_dw0(i_req_type, i_len);
            end
            HDR0: if (free) begin
                state_nxt = HDR1;
                tdata_nxt = dw1;
            end
            HDR1: if (free) begin
                state_nxt = HDR2;
                tdata_nxt = dw2;
            end
            HDR2: if (free) begin
                state_nxt  = DATA;
                tvalid_nxt = 1'b0;
            end
            DATA: if (free) begin
                state_nxt  = done ? IDLE : DATA;
                tvalid_nxt = load_data;
                tlast_nxt  = load_data && remaining == 11'd1;
                tdata_nxt  = load_data ? i_data : s_axis_tx_tdata;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            s_axis_tx_tvalid <= 1'b0;
            s_axis_tx_tlast  <= 1'b0;
            s_axis_tx_tdata  <= 32'd0;
            o_tlp_count      <= 32'd0;
            remaining        <= 11'd0;
        end else begin
            state            <= state_nxt;
            s_axis_tx_tvalid <= tvalid_nxt;
            s_axis_tx_tlast  <= tlast_nxt;
            s_axis_tx_tdata  <= tdata_nxt;
            o_tlp_count      <= o_tlp_count + {31'd0, done};
            remaining        <= accept ? (i_len == 10'd0 ? 11'(MAX_LEN_DW) : {1'b0, i_len})
                                       : remaining - {10'd0, load_data};
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            r_cpl        <= i_req_type;
            r_len        <= i_len;
            r_addr       <= i_addr;
            r_tag        <= i_tag;
            r_req_id     <= i_req_id;
            r_cpl_id     <= i_cpl_id;
            r_byte_count <= i_byte_count;
        end
    end
endmodule

// File: tb/tb_pcie_tx_tlp_builder.sv
// tb_pcie_tx_tlp_builder: randomized self-checking bench for pcie_tx_tlp_builder.
// Covers PCIE_TX_BUF_THROTTLE_EN when the macro is defined for the build.
module tb_pcie_tx_tlp_builder;
    typedef struct {
        logic        t;
        logic [9:0]  len;
        logic [31:0] addr;
        logic [7:0]  tag;
        logic [15:0] rid;
        logic [15:0] cid;
        logic [11:0] bc;
    } req_t;

    logic        clk = 0, rst = 1;
    logic        i_req_valid = 0, o_req_ready, i_req_type = 0;
    logic [9:0]  i_len = 0;
    logic [31:0] i_addr = 0;
    logic [7:0]  i_tag = 0;
    logic [15:0] i_req_id = 0, i_cpl_id = 0;
    logic [11:0] i_byte_count = 0;
    logic [31:0] i_data = 0;
    logic        i_data_valid = 0, o_data_ready;
    logic [31:0] s_axis_tx_tdata;
    logic [3:0]  s_axis_tx_tkeep, s_axis_tx_tuser;
    logic        s_axis_tx_tlast, s_axis_tx_tvalid, s_axis_tx_tready = 1;
    logic [5:0]  tx_buf_av = 6'd8;
    logic        o_busy;
    logic [31:0] o_tlp_count;

    int          checks = 0, passes = 0;
    int          rdy_mode = 0, hold_at = -1, hold_cnt = 0, popped = 0, bubbles = 0, early_rr = 0;
    bit          rand_gaps = 0, took = 0, prev_stall = 0;
    logic [31:0] prev_d;
    logic        prev_l;
    logic [31:0] exp_cnt = 0;
    logic [31:0] src_q[$];
    logic [40:0] cap[$];
    logic [40:0] exp_q[$];

    always #5 clk = ~clk;

    pcie_tx_tlp_builder dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_type(i_req_type),
        .i_len(i_len), .i_addr(i_addr), .i_tag(i_tag), .i_req_id(i_req_id),
        .i_cpl_id(i_cpl_id), .i_byte_count(i_byte_count),
        .i_data(i_data), .i_data_valid(i_data_valid), .o_data_ready(o_data_ready),
        .s_axis_tx_tdata(s_axis_tx_tdata), .s_axis_tx_tkeep(s_axis_tx_tkeep),
        .s_axis_tx_tuser(s_axis_tx_tuser), .s_axis_tx_tlast(s_axis_tx_tlast),
        .s_axis_tx_tvalid(s_axis_tx_tvalid), .s_axis_tx_tready(s_axis_tx_tready),
        .tx_buf_av(tx_buf_av), .o_busy(o_busy), .o_tlp_count(o_tlp_count)
    );

    // tready pattern: 0 always ready, 1 toggling, 2 random
    initial forever begin
        @(posedge clk); #1;
        s_axis_tx_tready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~s_axis_tx_tready : 1'($urandom_range(1));
    end

    // payload source: pops a word per handshake, optional forced hold and random gaps
    initial forever begin
        @(negedge clk);
        took = i_data_valid && o_data_ready;
        @(posedge clk); #1;
        if (took) begin
            void'(src_q.pop_front());
            popped++;
            if (popped == hold_at) hold_cnt = 5;
        end
        i_data_valid = src_q.size() > 0 && hold_cnt == 0 && !(rand_gaps && $urandom_range(3) == 0);
        i_data = src_q.size() > 0 ? src_q[0] : 32'd0;
        if (hold_cnt > 0) hold_cnt--;
    end

    // monitor: captures transferred beats and checks tvalid/tdata/tlast hold while stalled
    initial forever begin
        @(negedge clk);
        if (rst) prev_stall = 0;
        else begin
            if (prev_stall) begin
                checks++;
                if (s_axis_tx_tvalid !== 1'b1 || s_axis_tx_tdata !== prev_d || s_axis_tx_tlast !== prev_l)
                    $display("FAIL stall_hold: got v=%b d=%h l=%b required v=1 d=%h l=%b",
                             s_axis_tx_tvalid, s_axis_tx_tdata, s_axis_tx_tlast, prev_d, prev_l);
                else passes++;
            end
            if (s_axis_tx_tvalid && s_axis_tx_tready) begin
                cap.push_back({s_axis_tx_tuser, s_axis_tx_tkeep, s_axis_tx_tlast, s_axis_tx_tdata});
                if (s_axis_tx_tlast && o_req_ready) early_rr++;
            end
            if (o_busy && !s_axis_tx_tvalid) bubbles++;
            prev_stall = s_axis_tx_tvalid && !s_axis_tx_tready;
            prev_d = s_axis_tx_tdata;
            prev_l = s_axis_tx_tlast;
        end
    end

    // reference model: expected beats {tuser, tkeep, tlast, tdata} from the request fields
    function automatic void build_exp(input req_t r, input logic [31:0] pay[$]);
        logic [31:0] w[$];
        int n = (r.len == 0) ? 1024 : int'(r.len);
        w.push_back(32'h4000_0000 | (r.t ? 32'h0A00_0000 : 32'h0) | 32'(r.len));
        w.push_back(r.t ? (32'(r.cid) << 16) | 32'(r.bc)
                        : (32'(r.rid) << 16) | (32'(r.tag) << 8) | (n == 1 ? 32'h0F : 32'hFF));
        w.push_back(r.t ? (32'(r.rid) << 16) | (32'(r.tag) << 8) | (r.addr & 32'h7F)
                        : r.addr & 32'hFFFF_FFFC);
        foreach (pay[i]) w.push_back(pay[i]);
        exp_q.delete();
        foreach (w[i]) exp_q.push_back({4'h0, 4'hF, i == w.size() - 1, w[i]});
    endfunction

    function automatic int diff_at();
        for (int i = 0; i < exp_q.size() || i < cap.size(); i++)
            if (i >= cap.size() || i >= exp_q.size() || cap[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic run_tlp(input req_t r, input logic [31:0] fixed[$], output bit acc, output bit fin,
                           output logic v0, output logic [31:0] d0);
        logic [31:0] pay[$];
        int n = (r.len == 0) ? 1024 : int'(r.len);
        pay = fixed;
        while (pay.size() < n) pay.push_back($urandom);
        build_exp(r, pay);
        acc = 0; fin = 0; v0 = 0; d0 = 0;
        @(negedge clk);
        cap.delete();
        src_q = pay;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(posedge clk); #1;
            i_req_valid = 1; i_req_type = r.t; i_len = r.len; i_addr = r.addr;
            i_tag = r.tag; i_req_id = r.rid; i_cpl_id = r.cid; i_byte_count = r.bc;
            @(negedge clk);
            acc = o_req_ready;
        end
        @(posedge clk); #1;
        i_req_valid = 0; i_req_type = 1'($urandom); i_len = 10'($urandom); i_addr = $urandom;
        i_tag = 8'($urandom); i_req_id = 16'($urandom); i_cpl_id = 16'($urandom); i_byte_count = 12'($urandom);
        if (acc) begin
            @(negedge clk);
            v0 = s_axis_tx_tvalid;
            d0 = s_axis_tx_tdata;
            for (int c = 0; c < 6000 && cap.size() < exp_q.size(); c++) @(negedge clk);
            fin = cap.size() >= exp_q.size();
            @(posedge clk); #1;
            if (fin) exp_cnt++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({s_axis_tx_tvalid, s_axis_tx_tlast, s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tuser,
             o_data_ready, o_busy, o_req_ready} !== {2'b00, 32'd0, 4'hF, 4'h0, 3'b000})
            $display("FAIL reset_outputs: got v=%b l=%b d=%h k=%h u=%h dr=%b busy=%b rr=%b required 0,0,0,f,0,0,0,0",
                     s_axis_tx_tvalid, s_axis_tx_tlast, s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tuser,
                     o_data_ready, o_busy, o_req_ready);
        else passes++;
        checks++;
        if (o_tlp_count !== 32'd0) $display("FAIL reset_count: got %0d required 0", o_tlp_count);
        else passes++;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        checks++;
        if (o_req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b required 1", o_req_ready);
        else passes++;
    endtask

    task automatic test_mwr_single();
        req_t r = '{t: 1'b0, len: 10'd1, addr: 32'h0000_1000, tag: 8'h05, rid: 16'h0100, cid: 16'h0, bc: 12'h0};
        logic [31:0] want[4] = '{32'h4000_0001, 32'h0100_050F, 32'h0000_1000, 32'hDEADBEEF};
        logic [31:0] pay[$];
        bit acc, fin;
        logic v0;
        logic [31:0] d0;
        rdy_mode = 0;
        pay.push_back(32'hDEADBEEF);
        run_tlp(r, pay, acc, fin, v0, d0);
        checks++;
        if (!(acc && fin)) $display("FAIL mwr1_complete: got acc=%b fin=%b required 1,1", acc, fin);
        else passes++;
        checks++;
        if (v0 !== 1'b1 || d0 !== want[0])
            $display("FAIL mwr1_dw0_latency: got v=%b d=%h required v=1 d=%h", v0, d0, want[0]);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap.size() <= i || cap[i][31:0] !== want[i])
                $display("FAIL mwr1_beat%0d: got %h required %h", i, cap.size() > i ? cap[i][31:0] : 32'hx, want[i]);
            else passes++;
        end
        checks++;
        if (cap.size() != 4 || {cap[0][32], cap[1][32], cap[2][32], cap[3][32]} !== 4'b0001 || cap[3][40:33] !== 8'h0F)
            $display("FAIL mwr1_last_keep: got n=%0d last=%b%b%b%b required n=4 last=0001 keep=f user=0",
                     cap.size(), cap[0][32], cap[1][32], cap[2][32], cap[3][32]);
        else passes++;
        checks++;
        if (o_tlp_count !== exp_cnt) $display("FAIL mwr1_count: got %0d required %0d", o_tlp_count, exp_cnt);
        else passes++;
    endtask

    task automatic test_cpld();
        req_t r = '{t: 1'b1, len: 10'd4, addr: 32'hFFFF_FF90, tag: 8'h07, rid: 16'h0100, cid: 16'h0200, bc: 12'd16};
        logic [31:0] want[3] = '{32'h4A00_0004, 32'h0200_0010, 32'h0100_0710};
        logic [31:0] pay[$];
        bit acc, fin;
        logic v0;
        logic [31:0] d0;
        int d;
        run_tlp(r, pay, acc, fin, v0, d0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cap.size() <= i || cap[i][31:0] !== want[i])
                $display("FAIL cpld_hdr%0d: got %h required %h", i, cap.size() > i ? cap[i][31:0] : 32'hx, want[i]);
            else passes++;
        end
        checks++;
        if (cap.size() != 7 || !cap[6][32] || cap[5][32])
            $display("FAIL cpld_length: got %0d beats required 7 with tlast on 7th", cap.size());
        else passes++;
        d = diff_at();
        checks++;
        if (d != -1) $display("FAIL cpld_beats: beat %0d got %h required %h", d,
                              d < cap.size() ? cap[d] : 41'hx, d < exp_q.size() ? exp_q[d] : 41'hx);
        else passes++;
        checks++;
        if (o_tlp_count !== exp_cnt) $display("FAIL cpld_count: got %0d required %0d", o_tlp_count, exp_cnt);
        else passes++;
    endtask

    task automatic test_len1024_toggle();
        req_t r = '{t: 1'b0, len: 10'd0, addr: $urandom, tag: 8'($urandom), rid: 16'($urandom), cid: 16'h0, bc: 12'h0};
        logic [31:0] pay[$];
        bit acc, fin;
        logic v0;
        logic [31:0] d0;
        int d, lasts = 0;
        rdy_mode = 1;
        run_tlp(r, pay, acc, fin, v0, d0);
        rdy_mode = 0;
        foreach (cap[i]) lasts += int'(cap[i][32]);
        checks++;
        if (!fin || cap.size() != 1027 || lasts != 1)
            $display("FAIL len1024_count: got %0d beats %0d tlast required 1027 beats 1 tlast", cap.size(), lasts);
        else passes++;
        d = diff_at();
        checks++;
        if (d != -1) $display("FAIL len1024_order: beat %0d got %h required %h", d,
                              d < cap.size() ? cap[d] : 41'hx, d < exp_q.size() ? exp_q[d] : 41'hx);
        else passes++;
    endtask

    task automatic test_data_gaps();
        req_t r = '{t: 1'b0, len: 10'd10, addr: $urandom, tag: 8'($urandom), rid: 16'($urandom), cid: 16'h0, bc: 12'h0};
        logic [31:0] pay[$];
        bit acc, fin;
        logic v0;
        logic [31:0] d0;
        int d;
        bubbles = 0;
        hold_at = popped + 3;
        run_tlp(r, pay, acc, fin, v0, d0);
        hold_at = -1;
        checks++;
        if (bubbles < 5) $display("FAIL gaps_bubbles: got %0d idle busy cycles required >= 5", bubbles);
        else passes++;
        d = diff_at();
        checks++;
        if (!fin || d != -1) $display("FAIL gaps_payload: beat %0d got %h required %h", d,
                                      d >= 0 && d < cap.size() ? cap[d] : 41'hx, d >= 0 && d < exp_q.size() ? exp_q[d] : 41'hx);
        else passes++;
    endtask

    task automatic test_reset_mid();
        req_t r = '{t: 1'b0, len: 10'd8, addr: $urandom, tag: 8'($urandom), rid: 16'($urandom), cid: 16'h0, bc: 12'h0};
        logic [31:0] pay[$];
        bit acc, fin;
        logic v0;
        logic [31:0] d0;
        int d;
        @(negedge clk);
        cap.delete();
        for (int i = 0; i < 8; i++) src_q.push_back($urandom);
        @(posedge clk); #1;
        i_req_valid = 1; i_req_type = 0; i_len = 10'd8; i_addr = $urandom;
        @(negedge clk);
        @(posedge clk); #1;
        i_req_valid = 0;
        for (int c = 0; c < 100 && cap.size() < 4; c++) @(negedge clk);
        @(posedge clk); #1;
        rst = 1;
        #1;
        checks++;
        if ({s_axis_tx_tvalid, s_axis_tx_tlast, o_busy, o_req_ready, o_data_ready} !== 5'b0 || o_tlp_count !== 32'd0 || cap.size() != 4)
            $display("FAIL midreset_state: got v=%b l=%b busy=%b rr=%b dr=%b cnt=%0d beats=%0d required all 0 and 4 beats",
                     s_axis_tx_tvalid, s_axis_tx_tlast, o_busy, o_req_ready, o_data_ready, o_tlp_count, cap.size());
        else passes++;
        @(negedge clk);
        src_q.delete();
        exp_cnt = 0;
        @(posedge clk); #1;
        rst = 0;
        run_tlp(r, pay, acc, fin, v0, d0);
        d = diff_at();
        checks++;
        if (!fin || d != -1) $display("FAIL midreset_next_tlp: beat %0d got %h required %h", d,
                                      d >= 0 && d < cap.size() ? cap[d] : 41'hx, d >= 0 && d < exp_q.size() ? exp_q[d] : 41'hx);
        else passes++;
        checks++;
        if (o_tlp_count !== 32'd1) $display("FAIL midreset_count: got %0d required 1", o_tlp_count);
        else passes++;
    endtask

    task automatic test_throttle();
        req_t r = '{t: 1'b1, len: 10'd2, addr: $urandom, tag: 8'($urandom), rid: 16'($urandom), cid: 16'($urandom), bc: 12'($urandom)};
        logic [31:0] pay[$];
        bit acc, fin;
        logic v0;
        logic [31:0] d0;
        int d;
`ifdef PCIE_TX_BUF_THROTTLE_EN
        int blocked = 0;
        tx_buf_av = 6'd1;
        @(posedge clk); #1;
        i_req_valid = 1; i_req_type = r.t; i_len = r.len;
        repeat (8) begin
            @(negedge clk);
            if (o_req_ready || s_axis_tx_tvalid) blocked++;
        end
        checks++;
        if (blocked != 0) $display("FAIL throttle_hold: got %0d cycles ready/valid required 0", blocked);
        else passes++;
        @(posedge clk); #1;
        i_req_valid = 0;
        tx_buf_av = 6'd2;
`else
        tx_buf_av = 6'd0;
`endif
        run_tlp(r, pay, acc, fin, v0, d0);
        tx_buf_av = 6'd8;
        checks++;
        if (!acc || v0 !== 1'b1 || d0 !== exp_q[0][31:0])
            $display("FAIL throttle_accept: got acc=%b v=%b d=%h required 1,1,%h", acc, v0, d0, exp_q[0][31:0]);
        else passes++;
        d = diff_at();
        checks++;
        if (!fin || d != -1) $display("FAIL throttle_tlp: beat %0d got %h required %h", d,
                                      d >= 0 && d < cap.size() ? cap[d] : 41'hx, d >= 0 && d < exp_q.size() ? exp_q[d] : 41'hx);
        else passes++;
    endtask

    task automatic test_random();
        logic [31:0] pay[$];
        bit acc, fin;
        logic v0;
        logic [31:0] d0;
        int d;
        req_t r;
        rdy_mode = 2;
        rand_gaps = 1;
        early_rr = 0;
        for (int k = 0; k < 8; k++) begin
            r = '{t: 1'($urandom), len: k == 0 ? 10'd1 : 10'($urandom_range(1, 24)), addr: $urandom,
                  tag: 8'($urandom), rid: 16'($urandom), cid: 16'($urandom), bc: 12'($urandom)};
            run_tlp(r, pay, acc, fin, v0, d0);
            d = diff_at();
            checks++;
            if (!fin || d != -1) $display("FAIL random_tlp%0d: beat %0d got %h required %h", k, d,
                                          d >= 0 && d < cap.size() ? cap[d] : 41'hx, d >= 0 && d < exp_q.size() ? exp_q[d] : 41'hx);
            else passes++;
            checks++;
            if (o_tlp_count !== exp_cnt) $display("FAIL random_count%0d: got %0d required %0d", k, o_tlp_count, exp_cnt);
            else passes++;
        end
        rdy_mode = 0;
        rand_gaps = 0;
        checks++;
        if (early_rr != 0) $display("FAIL ready_after_last: got %0d early re-asserts required 0", early_rr);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_mwr_single();
        test_cpld();
        test_len1024_toggle();
        test_data_gaps();
        test_reset_mid();
        test_throttle();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/pcie_tx_tlp_builder.md
PCIE_TX_TLP_BUILDER -- requirements
Module: pcie_tx_tlp_builder

Interface
REQ-001 clk  in  1  user clock (user_clk_out of PCIe core); all logic on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 i_req_valid / o_req_ready  in/out  1/1  TLP request handshake.
REQ-004 i_req_type  in  1  0 = MWr32, 1 = CplD.
REQ-005 i_len  in  10  payload length in DW; 0 encodes 1024.
REQ-006 i_addr  in  32  MWr address (bits 1:0 ignored); CplD lower address from i_addr[6:0].
REQ-007 i_tag, i_req_id, i_cpl_id, i_byte_count  in  8/16/16/12  header fields.
REQ-008 i_data / i_data_valid / o_data_ready  in/in/out  32/1/1  payload source handshake.
REQ-009 s_axis_tx_tdata/tkeep/tuser/tlast/tvalid  out  32/4/4/1/1; s_axis_tx_tready  in  1.
REQ-010 tx_buf_av  in  6  free transmit buffers reported by the PCIe core.
REQ-011 o_busy  out  1  high from request accept until the last beat transfers.
REQ-012 o_tlp_count  out  32  count of completed TLPs, wraps at 2^32.

Function
REQ-013 Beat transfers when s_axis_tx_tvalid && s_axis_tx_tready; outputs are registered and update only when !tvalid || tready.
REQ-014 tvalid, once high, stays high with data/tlast stable until tready.
REQ-015 States: IDLE, HDR0, HDR1, HDR2, DATA.
REQ-016 IDLE: o_req_ready=1; on i_req_valid, latch all request fields and go HDR0; DW0 valid on the next cycle (1-cycle latency).
REQ-017 HDR0 beat DW0 = {0, fmt=2'b10, type (5'b00000 MWr / 5'b01010 CplD), 0, tc=0, 4'b0, td=0, ep=0, attr=0, 2'b0, i_len}.
REQ-018 HDR1 beat: MWr {i_req_id, i_tag, last_be, first_be=4'hF}, last_be=4'hF unless length 1 then 4'h0; CplD {i_cpl_id, status=3'b000, bcm=0, i_byte_count}.
REQ-019 HDR2 beat: MWr {i_addr[31:2], 2'b00}; CplD {i_req_id, i_tag, 1'b0, i_addr[6:0]}.
REQ-020 DATA: o_data_ready = output register free && beats remaining > 0; each accepted i_data becomes one beat; 11-bit remaining counter loaded with 1..1024.
REQ-021 tlast=1 only on the final payload beat; tkeep=4'hF and tuser=4'h0 on every beat.
REQ-022 After final beat transfers: o_tlp_count+1, return to IDLE; o_req_ready is re-asserted no earlier than the cycle after.
REQ-023 i_data_valid low in DATA inserts bubbles (tvalid low); no error, no timeout.
REQ-024 tready held low: all state and counters frozen; no beat lost or duplicated.
REQ-025 Request fields change after acceptance have no effect on the TLP in flight.

Reset
REQ-026 rst asserted at any time, including mid-TLP: state IDLE, tvalid=0, tlast=0, tdata=0, tkeep=4'hF, tuser=0, o_data_ready=0, o_busy=0, o_tlp_count=0, o_req_ready=0 while rst high; a partial TLP is abandoned, not completed.

Configuration
REQ-027 Macro PCIE_TX_BUF_THROTTLE_EN defined: IDLE holds o_req_ready=0 while tx_buf_av < 2; a TLP already started is never throttled.
REQ-028 Macro undefined: tx_buf_av ignored; o_req_ready depends on state only.

Structure
REQ-029 Shared package pcie_tlp_pkg: fmt/type codes, state encoding, TX_BUF_AV_MIN=2, MAX_LEN_DW=1024.
REQ-030 Single module; no sub-module required.

Verification
REQ-031 MWr32 len=1, addr 32'h0000_1000, tag 8'h05, req_id 16'h0100, data 32'hDEADBEEF, tready=1 -> beats 32'h4000_0001, 32'h0100_050F, 32'h0000_1000, 32'hDEADBEEF with tlast on beat 4; o_tlp_count=1.
REQ-032 CplD len=4, byte_count 16, cpl_id 16'h0200, req_id 16'h0100, tag 8'h07, addr[6:0]=7'h10 -> DW0 32'h4A00_0004, DW1 32'h0200_0010, DW2 32'h0100_0710, 4 data beats, tlast on 7th beat.
REQ-033 len=0 with tready toggling every other cycle -> 3 header + 1024 data beats in order, single tlast, no drops.
REQ-034 rst pulsed during data beat 2 of len=8 MWr -> tvalid=0 next cycle, o_tlp_count=0; next request emits a clean full TLP.
REQ-035 PCIE_TX_BUF_THROTTLE_EN defined, tx_buf_av=1 -> o_req_ready=0 and no beats; raise tx_buf_av to 2 -> request accepted, DW0 appears the following cycle.
REQ-036 i_data_valid low for 5 cycles mid-payload -> tvalid low for those cycles; payload order and count intact.
